// File: rtl/spi_register_file.sv
// Bank of multi-byte SPI registers on the shared opcode/operand bus.
// Reads come from a snapshot taken at transaction start; writes commit atomically on the last byte.
module spi_register_file #(
    parameter int unsigned BASE_ADDRESS   = 'hD0,
    parameter int unsigned REGISTER_COUNT = 4,
    parameter int unsigned REGISTER_BYTES = 2,
    parameter logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] RESET_VALUE = '0,
    parameter logic [REGISTER_COUNT-1:0] WRITABLE_MASK = '1
) (
    input  logic                                       clock_in,
    input  logic                                       reset_in,
    input  logic [7:0]                                 opcode_in,
    input  logic                                       opcode_valid_in,
    input  logic [7:0]                                 operand_in,
    input  logic                                       operand_valid_in,
    input  logic [31:0]                                operand_count_in,
    output logic [7:0]                                 response_out,
    output logic                                       response_valid_out,
    output logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] register_values_out,
    output logic [REGISTER_COUNT-1:0]                  write_strobe_out,
    input  logic [REGISTER_COUNT-1:0]                  hw_load_in,
    input  logic [REGISTER_COUNT*REGISTER_BYTES*8-1:0] hw_value_in
);

    localparam int unsigned REG_W   = REGISTER_BYTES * 8;
    localparam int unsigned INDEX_W = (REGISTER_COUNT > 1) ? $clog2(REGISTER_COUNT) : 1;
    localparam int unsigned PTR_W   = $clog2(REGISTER_BYTES + 1);

    localparam logic [8:0]       BASE    = 9'(BASE_ADDRESS);
    localparam logic [8:0]       COUNT9  = 9'(REGISTER_COUNT);
    localparam logic [31:0]      BYTES32 = 32'(REGISTER_BYTES);
    localparam logic [31:0]      LAST32  = 32'(REGISTER_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(REGISTER_BYTES);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        IGNORE
    } state_t;

    state_t state, state_next;

    logic                  opcode_valid_q;
    logic                  opcode_rise;
    logic [8:0]            offset;
    logic                  in_range;
    logic                  enter;
    logic [INDEX_W-1:0]    index;
    logic [REG_W-1:0]      regs [REGISTER_COUNT];
    logic [REG_W-1:0]      snapshot;
    logic [REG_W-1:0]      shadow;
    logic [REG_W-1:0]      merged;
    logic [PTR_W-1:0]      read_ptr;
    logic                  write_accept;
    logic                  commit;
    logic [REGISTER_COUNT-1:0] strobe;

    assign opcode_rise = opcode_valid_in && !opcode_valid_q;
    // Opcodes below the base wrap to >= 257 in 9 bits, so one compare covers both ends.
    assign offset   = {1'b0, opcode_in} - BASE;
    assign in_range = (offset < COUNT9);
    assign enter    = (state == IDLE) && opcode_rise && in_range;

    assign write_accept = (state == ACTIVE) && operand_valid_in &&
                          WRITABLE_MASK[index] && (operand_count_in < BYTES32);
    assign commit       = write_accept && (operand_count_in == LAST32);

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next         = state;
        response_valid_out = 1'b0;
        response_out       = '0;
        case (state)
            IDLE: begin
                if (opcode_rise) begin
                    state_next = in_range ? ACTIVE : IGNORE;
                end
            end
            ACTIVE: begin
                response_valid_out = 1'b1;
                for (int unsigned b = 0; b < REGISTER_BYTES; b++) begin
                    if (read_ptr == PTR_W'(b)) begin
                        response_out = snapshot[(REGISTER_BYTES - 1 - b) * 8 +: 8];
                    end
                end
                if (!opcode_valid_in) begin
                    state_next = IDLE;
                end
            end
            IGNORE: begin
                if (!opcode_valid_in) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow with the current operand byte merged in, big-endian (byte 0 = MSB).
    always_comb begin
        merged = shadow;
        for (int unsigned b = 0; b < REGISTER_BYTES; b++) begin
            if (operand_count_in == 32'(b)) begin
                merged[(REGISTER_BYTES - 1 - b) * 8 +: 8] = operand_in;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            opcode_valid_q <= 1'b1;
            index          <= '0;
            snapshot       <= '0;
            shadow         <= '0;
            read_ptr       <= '0;
            strobe         <= '0;
            for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
                regs[i] <= RESET_VALUE[i * REG_W +: REG_W];
            end
        end else begin
            opcode_valid_q <= opcode_valid_in;
            strobe         <= '0;

            if (enter) begin
                index    <= offset[INDEX_W-1:0];
                snapshot <= regs[offset[INDEX_W-1:0]];
                shadow   <= '0;
                read_ptr <= '0;
            end else if (state == ACTIVE && operand_valid_in && read_ptr != PTR_MAX) begin
                read_ptr <= read_ptr + PTR_W'(1);
            end

            if (write_accept) begin
                shadow <= merged;
            end

            // An SPI commit takes priority over a hardware load to the same register.
            for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
                if (commit && index == INDEX_W'(i)) begin
                    regs[i]   <= merged;
                    strobe[i] <= 1'b1;
                end else if (hw_load_in[i]) begin
                    regs[i] <= hw_value_in[i * REG_W +: REG_W];
                end
            end
        end
    end

    always_comb begin
        register_values_out = '0;
        for (int unsigned i = 0; i < REGISTER_COUNT; i++) begin
            register_values_out[i * REG_W +: REG_W] = regs[i];
        end
    end

    assign write_strobe_out = strobe;

endmodule

// File: tb/tb_spi_register_file.sv
// Scoreboard bench for spi_register_file: two instances (fully writable and register 0 read-only)
// share stimulus; expected bytes and strobes are queued by the driver and checked by monitors.
module tb_spi_register_file;

    localparam int RC = 4;
    localparam int RB = 2;
    localparam int W  = RC * RB * 8;
    localparam logic [W-1:0] RST = 64'hA1B2_C3D4_E5F6_0718;

    logic          clk = 1'b0;
    logic          reset_in;
    logic [7:0]    opcode_in;
    logic          opcode_valid_in;
    logic [7:0]    operand_in;
    logic          operand_valid_in;
    logic [31:0]   operand_count_in;
    logic [RC-1:0] hw_load_in;
    logic [W-1:0]  hw_value_in;

    logic [7:0]    resp_a, resp_b;
    logic          valid_a, valid_b;
    logic [W-1:0]  values_a, values_b;
    logic [RC-1:0] strobe_a, strobe_b;

    always #5 clk = ~clk;

    spi_register_file #(
        .BASE_ADDRESS(32'hD0), .REGISTER_COUNT(RC), .REGISTER_BYTES(RB),
        .RESET_VALUE(RST), .WRITABLE_MASK(4'b1111)
    ) dut_a (
        .clock_in(clk), .reset_in(reset_in),
        .opcode_in(opcode_in), .opcode_valid_in(opcode_valid_in),
        .operand_in(operand_in), .operand_valid_in(operand_valid_in),
        .operand_count_in(operand_count_in),
        .response_out(resp_a), .response_valid_out(valid_a),
        .register_values_out(values_a), .write_strobe_out(strobe_a),
        .hw_load_in(hw_load_in), .hw_value_in(hw_value_in)
    );

    spi_register_file #(
        .BASE_ADDRESS(32'hD0), .REGISTER_COUNT(RC), .REGISTER_BYTES(RB),
        .RESET_VALUE(RST), .WRITABLE_MASK(4'b1110)
    ) dut_b (
        .clock_in(clk), .reset_in(reset_in),
        .opcode_in(opcode_in), .opcode_valid_in(opcode_valid_in),
        .operand_in(operand_in), .operand_valid_in(operand_valid_in),
        .operand_count_in(operand_count_in),
        .response_out(resp_b), .response_valid_out(valid_b),
        .register_values_out(values_b), .write_strobe_out(strobe_b),
        .hw_load_in(hw_load_in), .hw_value_in(hw_value_in)
    );

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } resp_t;

    typedef struct packed {
        logic [RC-1:0] sa;
        logic [RC-1:0] sb;
        logic [W-1:0]  va;
        logic [W-1:0]  vb;
    } strb_t;

    resp_t rq[$];
    strb_t sq[$];
    resp_t re;
    strb_t se;

    int checks = 0;
    int fails  = 0;

    logic [15:0]  ma [RC];
    logic [15:0]  mb [RC];
    logic [W-1:0] rst_v;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] flat_model(input bit use_b);
        logic [W-1:0] f;
        for (int i = 0; i < RC; i++) f[i*16 +: 16] = use_b ? mb[i] : ma[i];
        return f;
    endfunction

    function automatic logic [7:0] byte_at(input logic [15:0] v, input int p);
        if (p == 0) return v[15:8];
        if (p == 1) return v[7:0];
        return 8'h00;
    endfunction

    task automatic reset_models();
        for (int i = 0; i < RC; i++) begin
            ma[i] = rst_v[i*16 +: 16];
            mb[i] = rst_v[i*16 +: 16];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_regs_a"}, values_a, flat_model(0));
        chk({tag, "_regs_b"}, values_b, flat_model(1));
    endtask

    // Response monitor: one expected entry per cycle the block owns the transaction.
    always @(negedge clk) begin
        if (valid_a || valid_b) begin
            if (rq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_response: valid_a=%0b valid_b=%0b resp_a=%0h resp_b=%0h",
                         valid_a, valid_b, resp_a, resp_b);
            end else begin
                re = rq.pop_front();
                chk("valid_a", 64'(valid_a), 64'd1);
                chk("valid_b", 64'(valid_b), 64'd1);
                chk("resp_a", 64'(resp_a), 64'(re.a));
                chk("resp_b", 64'(resp_b), 64'(re.b));
            end
        end
    end

    // Strobe monitor: every strobe pulse must match a queued commit and its register image.
    always @(negedge clk) begin
        if (strobe_a != '0 || strobe_b != '0) begin
            if (sq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_strobe: strobe_a=%0b strobe_b=%0b", strobe_a, strobe_b);
            end else begin
                se = sq.pop_front();
                chk("strobe_a", 64'(strobe_a), 64'(se.sa));
                chk("strobe_b", 64'(strobe_b), 64'(se.sb));
                chk("commit_regs_a", values_a, se.va);
                chk("commit_regs_b", values_b, se.vb);
            end
        end
    end

    // Hardware load (hwm/hwv) is applied together with the last operand pulse.
    task automatic txn(input logic [7:0] op, input int nops,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       input logic [RC-1:0] hwm, input logic [W-1:0] hwv);
        logic [7:0]    d [3];
        logic          in_rng;
        int            idx;
        int            ptr;
        logic [15:0]   sa, sb;
        logic          ca, cb;
        logic [RC-1:0] exp_sa, exp_sb;
        d[0] = d0; d[1] = d1; d[2] = d2;
        in_rng = (op >= 8'hD0) && (op <= 8'hD3);
        idx = int'(op) - 'hD0;
        ptr = 0;
        sa = '0; sb = '0;
        if (in_rng) begin
            sa = ma[idx];
            sb = mb[idx];
        end
        opcode_in = op;
        opcode_valid_in = 1'b1;
        operand_valid_in = 1'b0;
        if (in_rng) rq.push_back({byte_at(sa, 0), byte_at(sb, 0)});
        cycle();
        if (!in_rng) chk("ignore_valid", 64'({valid_a, valid_b}), 64'd0);
        for (int k = 0; k < nops; k++) begin
            operand_in = d[k];
            operand_count_in = 32'(k);
            operand_valid_in = 1'b1;
            ca = 1'b0; cb = 1'b0;
            exp_sa = '0; exp_sb = '0;
            if (k == nops - 1) begin
                hw_load_in = hwm;
                hw_value_in = hwv;
            end
            if (in_rng) begin
                ptr = (ptr < 2) ? ptr + 1 : 2;
                rq.push_back({byte_at(sa, ptr), byte_at(sb, ptr)});
                if (k == 1) begin
                    ca = 1'b1;
                    cb = (idx != 0);
                    if (ca) begin ma[idx] = {d[0], d[1]}; exp_sa = RC'(1 << idx); end
                    if (cb) begin mb[idx] = {d[0], d[1]}; exp_sb = RC'(1 << idx); end
                end
            end
            if (k == nops - 1) begin
                for (int i = 0; i < RC; i++) begin
                    if (hwm[i] && !(ca && idx == i)) ma[i] = hwv[i*16 +: 16];
                    if (hwm[i] && !(cb && idx == i)) mb[i] = hwv[i*16 +: 16];
                end
            end
            if (ca || cb) sq.push_back({exp_sa, exp_sb, flat_model(0), flat_model(1)});
            cycle();
            hw_load_in = '0;
        end
        operand_valid_in = 1'b0;
        if (in_rng) rq.push_back({byte_at(sa, ptr), byte_at(sb, ptr)});
        cycle();
        opcode_valid_in = 1'b0;
        cycle();
        chk("end_valid", 64'({valid_a, valid_b}), 64'd0);
        chk("end_resp", 64'({resp_a, resp_b}), 64'd0);
        check_regs("after_txn");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_v = RST;
        reset_models();
        reset_in = 1'b1;
        opcode_in = '0;
        opcode_valid_in = 1'b0;
        operand_in = '0;
        operand_valid_in = 1'b0;
        operand_count_in = '0;
        hw_load_in = '0;
        hw_value_in = '0;
        repeat (3) cycle();
        chk("reset_valid", 64'({valid_a, valid_b}), 64'd0);
        chk("reset_resp", 64'({resp_a, resp_b}), 64'd0);
        chk("reset_strobe", 64'({strobe_a, strobe_b}), 64'd0);
        check_regs("reset");
        reset_in = 1'b0;
        cycle();

        // Read reg1 with three pulses: E5, F6, 00 (the two bytes rewrite the same value).
        txn(8'hD1, 3, 8'hE5, 8'hF6, 8'h77, '0, '0);
        // Write reg2 = ABCD, then read it back.
        txn(8'hD2, 2, 8'hAB, 8'hCD, 8'h00, '0, '0);
        txn(8'hD2, 2, 8'hAB, 8'hCD, 8'h00, '0, '0);
        // Partial write to reg0 is discarded.
        txn(8'hD0, 1, 8'h12, 8'h00, 8'h00, '0, '0);
        // Full write to reg0: commits in dut_a, ignored by read-only reg0 in dut_b.
        txn(8'hD0, 2, 8'h55, 8'h66, 8'h00, '0, '0);
        // SPI commit to reg3 wins over a simultaneous hw load; hw load to reg1 proceeds.
        txn(8'hD3, 2, 8'h12, 8'h34, 8'h00, 4'b1010, 64'hFFFF_0000_0F0F_0000);

        // Standalone hardware load of reg0.
        hw_load_in = 4'b0001;
        hw_value_in = 64'h0000_0000_0000_BEEF;
        ma[0] = 16'hBEEF;
        mb[0] = 16'hBEEF;
        cycle();
        hw_load_in = '0;
        check_regs("hw_load");

        // Out-of-range opcodes above and below the window.
        txn(8'hD4, 2, 8'h99, 8'h88, 8'h00, '0, '0);
        txn(8'hCF, 2, 8'h99, 8'h88, 8'h00, '0, '0);
        // Snapshot holds 1234 even though reg3 is hw-loaded mid-read.
        txn(8'hD3, 1, 8'h99, 8'h00, 8'h00, 4'b1000, 64'h5A5A_0000_0000_0000);

        // Reset during a read of reg1 with opcode_valid held high.
        opcode_in = 8'hD1;
        opcode_valid_in = 1'b1;
        rq.push_back({byte_at(ma[1], 0), byte_at(mb[1], 0)});
        cycle();
        operand_in = 8'h00;
        operand_count_in = 32'd0;
        operand_valid_in = 1'b1;
        rq.push_back({byte_at(ma[1], 1), byte_at(mb[1], 1)});
        cycle();
        operand_valid_in = 1'b0;
        reset_in = 1'b1;
        cycle();
        reset_models();
        chk("midreset_valid", 64'({valid_a, valid_b}), 64'd0);
        chk("midreset_resp", 64'({resp_a, resp_b}), 64'd0);
        chk("midreset_strobe", 64'({strobe_a, strobe_b}), 64'd0);
        check_regs("midreset");
        reset_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("no_reentry", 64'({valid_a, valid_b}), 64'd0);
        end
        opcode_valid_in = 1'b0;
        cycle();
        // One low cycle is enough for the next transaction to open.
        txn(8'hD1, 1, 8'h00, 8'h00, 8'h00, '0, '0);

        repeat (3) cycle();
        chk("resp_queue_drained", 64'(rq.size()), 64'd0);
        chk("strobe_queue_drained", 64'(sq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
